// File: rtl/pin_vault.sv
// ---------------------------------------------------------------------------
// pin_vault
//   Stores a four-digit BCD PIN and grants access when a matching candidate
//   is presented. Wrong candidates consume attempts; running out of attempts
//   locks the vault for LOCK_CYCLES clock cycles.
//
// Optional build macro:
//   PIN_VAULT_WIPE_EN - a second lockout with no successful match since the
//                       previous lockout wipes the stored PIN on expiry and
//                       returns the vault to the empty (un-enrolled) state.
//
// Ports:
//   clk_i           single clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   enroll_valid_i  request to store enroll_pin_i
//   enroll_pin_i    four BCD digits, digit k at [4k+3:4k]
//   check_valid_i   request to compare check_pin_i with the stored PIN
//   check_pin_i     candidate PIN, same layout as enroll_pin_i
//   relock_i        close an open vault
//   ready_o         a request is accepted on an edge where this is high
//   enrolled_o      a PIN is stored
//   w_o             access granted (level)
//   fail_o          one-cycle failure pulse
//   locked_o        lockout in progress
//   attempts_o      wrong checks remaining before lockout
// ---------------------------------------------------------------------------
module pin_vault #(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 50000000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enroll_valid_i,
  input  logic [15:0] enroll_pin_i,
  input  logic        check_valid_i,
  input  logic [15:0] check_pin_i,
  input  logic        relock_i,
  output logic        ready_o,
  output logic        enrolled_o,
  output logic        w_o,
  output logic        fail_o,
  output logic        locked_o,
  output logic [1:0]  attempts_o
);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_IDLE,
    S_COMPARE,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  localparam logic [1:0]  ATT_MAX = 2'(MAX_ATTEMPTS);
  localparam logic [25:0] LOCK_LD = 26'(LOCK_CYCLES);

  function automatic logic bcd_ok(input logic [15:0] pin);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (pin[4*k +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pin;
  logic [15:0] r_cand;
  logic [1:0]  r_attempts;
  logic [25:0] r_timer;
  logic        r_w;
  logic        r_fail;
  logic        r_fail_p1;

  logic        w_enr_bcd;
  logic        w_match;
  logic        w_expire;
  logic        w_lock_enter;
  logic        w_store_pin;
  logic        w_fail_now;
  logic        w_wipe;
  logic        w_wipe_exp;

  assign w_enr_bcd    = bcd_ok(enroll_pin_i);
  // Stored PIN is always valid BCD, so equality already implies a valid
  // candidate; the explicit digit test keeps the intent visible.
  assign w_match      = (r_cand == r_pin) && bcd_ok(r_cand);
  assign w_expire     = (r_state == S_LOCKOUT) && (r_timer <= 26'd1);
  assign w_lock_enter = (r_state == S_COMPARE) && !w_match && (r_attempts <= 2'd1);
  assign w_wipe_exp   = w_expire && w_wipe;

  // A check wins over an enroll in EMPTY; relock wins over enroll in OPEN.
  assign w_store_pin  = enroll_valid_i && w_enr_bcd &&
                        (((r_state == S_EMPTY) && !check_valid_i) ||
                         ((r_state == S_OPEN)  && !relock_i));

  assign w_fail_now   = ((r_state == S_EMPTY) && check_valid_i) ||
                        ((r_state == S_EMPTY) && enroll_valid_i && !w_enr_bcd) ||
                        ((r_state == S_OPEN)  && !relock_i && enroll_valid_i && !w_enr_bcd);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (!check_valid_i && enroll_valid_i && w_enr_bcd) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (check_valid_i) w_state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_match)           w_state_nxt = S_OPEN;
        else if (w_lock_enter) w_state_nxt = S_LOCKOUT;
        else                   w_state_nxt = S_IDLE;
      end
      S_OPEN: begin
        if (relock_i) w_state_nxt = S_IDLE;
      end
      S_LOCKOUT: begin
        if (w_expire) w_state_nxt = w_wipe ? S_EMPTY : S_IDLE;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_o    = (r_state == S_EMPTY) || (r_state == S_IDLE) || (r_state == S_OPEN);
    locked_o   = (r_state == S_LOCKOUT);
    enrolled_o = (r_state != S_EMPTY);
  end

  assign w_o        = r_w;
  assign fail_o     = r_fail;
  assign attempts_o = r_attempts;

  // Candidate capture (accept edge); no reset needed, only read in COMPARE
  always_ff @(posedge clk_i) begin
    if ((r_state == S_IDLE) && check_valid_i) r_cand <= check_pin_i;
  end

  // Compare result -> p1 (state update), p1 -> output pulse/level.
  // w_o follows OPEN one edge late so a grant appears two edges after the
  // accepting edge, but relock clears it on the relock edge itself.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pin      <= '0;
      r_attempts <= ATT_MAX;
      r_timer    <= '0;
      r_w        <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_p1  <= 1'b0;
    end else begin
      r_w       <= (r_state == S_OPEN) && !relock_i;
      r_fail_p1 <= (r_state == S_COMPARE) && !w_match;
      r_fail    <= r_fail_p1 || w_fail_now;

      if (w_store_pin)     r_pin <= enroll_pin_i;
      else if (w_wipe_exp) r_pin <= '0;

      if (r_state == S_COMPARE) r_attempts <= w_match ? ATT_MAX : (r_attempts - 2'd1);
      else if (w_expire)        r_attempts <= ATT_MAX;

      if (w_lock_enter)                                 r_timer <= LOCK_LD;
      else if ((r_state == S_LOCKOUT) && (r_timer != '0)) r_timer <= r_timer - 26'd1;
    end
  end

`ifdef PIN_VAULT_WIPE_EN
  // r_hist: a lockout happened with no successful match since.
  // r_wipe: the current lockout is a repeat and ends in a wipe.
  logic r_hist;
  logic r_wipe;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_hist <= 1'b0;
      r_wipe <= 1'b0;
    end else if ((r_state == S_COMPARE) && w_match) begin
      r_hist <= 1'b0;
      r_wipe <= 1'b0;
    end else if (w_lock_enter) begin
      r_wipe <= r_hist;
      r_hist <= 1'b1;
    end else if (w_wipe_exp) begin
      r_hist <= 1'b0;
      r_wipe <= 1'b0;
    end
  end

  assign w_wipe = r_wipe;
`else
  assign w_wipe = 1'b0;
`endif

endmodule

// File: tb/tb_pin_vault.sv
module tb_pin_vault;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        enroll_valid_i = 1'b0;
  logic [15:0] enroll_pin_i = '0;
  logic        check_valid_i = 1'b0;
  logic [15:0] check_pin_i = '0;
  logic        relock_i = 1'b0;
  logic        ready_o, enrolled_o, w_o, fail_o, locked_o;
  logic [1:0]  attempts_o;

  int n_cmp = 0;
  int n_bad = 0;

  pin_vault #(.MAX_ATTEMPTS(3), .LOCK_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .enroll_valid_i(enroll_valid_i), .enroll_pin_i(enroll_pin_i),
    .check_valid_i(check_valid_i), .check_pin_i(check_pin_i),
    .relock_i(relock_i), .ready_o(ready_o), .enrolled_o(enrolled_o),
    .w_o(w_o), .fail_o(fail_o), .locked_o(locked_o), .attempts_o(attempts_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    enroll_valid_i = 1'b0;
    check_valid_i  = 1'b0;
    relock_i       = 1'b0;
    rst_n_i        = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic do_enroll(input logic [15:0] pin);
    enroll_pin_i   = pin;
    enroll_valid_i = 1'b1;
    tick();
    enroll_valid_i = 1'b0;
  endtask

  task automatic do_check(input logic [15:0] pin);
    check_pin_i   = pin;
    check_valid_i = 1'b1;
    tick();
    check_valid_i = 1'b0;
  endtask

  // Three wrong checks, then wait out the lockout (bounded).
  task automatic burn_lockout(output bit tmo);
    int cyc;
    for (int i = 0; i < 3; i++) begin
      do_check(16'h1235);
      tick();
      tick();
    end
    cyc = 0;
    while (locked_o && cyc < 40) begin
      tick();
      cyc++;
    end
    tmo = (cyc >= 40);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #13;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    n_cmp++; if (enrolled_o !== 1'b0) begin n_bad++; $display("FAIL rst_enrolled: got %b want 0", enrolled_o); end
    n_cmp++; if (w_o !== 1'b0) begin n_bad++; $display("FAIL rst_w: got %b want 0", w_o); end
    n_cmp++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL rst_fail: got %b want 0", fail_o); end
    n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL rst_locked: got %b want 0", locked_o); end
    n_cmp++; if (attempts_o !== 2'd3) begin n_bad++; $display("FAIL rst_attempts: got %0d want 3", attempts_o); end
    tick();
    rst_n_i = 1'b1;
  endtask

  task automatic test_match();
    do_reset();
    do_enroll(16'h1234);
    n_cmp++; if (enrolled_o !== 1'b1) begin n_bad++; $display("FAIL match_enrolled: got %b want 1", enrolled_o); end
    do_check(16'h1234);
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL match_cmp_ready: got %b want 0", ready_o); end
    tick();
    n_cmp++; if (w_o !== 1'b0) begin n_bad++; $display("FAIL match_w_edge1: got %b want 0", w_o); end
    tick();
    n_cmp++; if (w_o !== 1'b1) begin n_bad++; $display("FAIL match_w_edge2: got %b want 1", w_o); end
    n_cmp++; if (attempts_o !== 2'd3) begin n_bad++; $display("FAIL match_attempts: got %0d want 3", attempts_o); end
    n_cmp++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL match_fail: got %b want 0", fail_o); end
  endtask

  task automatic test_lockout();
    int lk;
    int cyc;
    logic [1:0] exp_att;
    do_reset();
    do_enroll(16'h1234);
    for (int i = 0; i < 2; i++) begin
      exp_att = 2'(2 - i);
      do_check(16'h1235);
      tick();
      n_cmp++; if (attempts_o !== exp_att) begin n_bad++; $display("FAIL lock_attempts%0d: got %0d want %0d", i, attempts_o, exp_att); end
      tick();
      n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL lock_fail_pulse%0d: got %b want 1", i, fail_o); end
      tick();
      n_cmp++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL lock_fail_end%0d: got %b want 0", i, fail_o); end
    end
    do_check(16'h1235);
    tick();
    n_cmp++; if (attempts_o !== 2'd0) begin n_bad++; $display("FAIL lock_attempts2: got %0d want 0", attempts_o); end
    n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL lock_entry: got %b want 1", locked_o); end
    // Correct PIN held on the check port throughout lockout must be ignored.
    check_pin_i   = 16'h1234;
    check_valid_i = 1'b1;
    lk  = 1;
    cyc = 0;
    while (cyc < 30) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL lock_fail_pulse2: got %b want 1", fail_o); end
      end
      if (!locked_o) break;
      lk++;
      n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL lock_ready: got %b want 0", ready_o); end
    end
    check_valid_i = 1'b0;
    n_cmp++; if (lk !== 8) begin n_bad++; $display("FAIL lock_duration: got %0d want 8", lk); end
    n_cmp++; if (attempts_o !== 2'd3) begin n_bad++; $display("FAIL lock_reload: got %0d want 3", attempts_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL lock_idle_ready: got %b want 1", ready_o); end
    n_cmp++; if (w_o !== 1'b0) begin n_bad++; $display("FAIL lock_ignored_check: w_o got %b want 0", w_o); end
    n_cmp++; if (enrolled_o !== 1'b1) begin n_bad++; $display("FAIL lock_enrolled: got %b want 1", enrolled_o); end
  endtask

  task automatic test_bad_bcd();
    do_reset();
    do_enroll(16'h12A4);
    n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL bcd_fail: got %b want 1", fail_o); end
    n_cmp++; if (enrolled_o !== 1'b0) begin n_bad++; $display("FAIL bcd_enrolled: got %b want 0", enrolled_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL bcd_ready: got %b want 1", ready_o); end
    tick();
    n_cmp++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL bcd_fail_end: got %b want 0", fail_o); end
    do_check(16'h1234);
    n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL empty_check_fail: got %b want 1", fail_o); end
    n_cmp++; if (enrolled_o !== 1'b0) begin n_bad++; $display("FAIL empty_check_enrolled: got %b want 0", enrolled_o); end
  endtask

  task automatic test_open_reenroll();
    do_reset();
    do_enroll(16'h1234);
    do_check(16'h1234);
    tick();
    tick();
    n_cmp++; if (w_o !== 1'b1) begin n_bad++; $display("FAIL open_w: got %b want 1", w_o); end
    do_enroll(16'h98F6);
    n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL open_badbcd_fail: got %b want 1", fail_o); end
    n_cmp++; if (w_o !== 1'b1) begin n_bad++; $display("FAIL open_badbcd_w: got %b want 1", w_o); end
    do_enroll(16'h9876);
    n_cmp++; if (fail_o !== 1'b0) begin n_bad++; $display("FAIL open_enroll_fail: got %b want 0", fail_o); end
    // Relock and enroll together: relock wins, 1111 must not be stored.
    relock_i       = 1'b1;
    enroll_pin_i   = 16'h1111;
    enroll_valid_i = 1'b1;
    tick();
    relock_i       = 1'b0;
    enroll_valid_i = 1'b0;
    n_cmp++; if (w_o !== 1'b0) begin n_bad++; $display("FAIL relock_w: got %b want 0", w_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL relock_ready: got %b want 1", ready_o); end
    do_check(16'h9876);
    tick();
    tick();
    n_cmp++; if (w_o !== 1'b1) begin n_bad++; $display("FAIL new_pin_w: got %b want 1", w_o); end
    relock_i = 1'b1;
    tick();
    relock_i = 1'b0;
    do_check(16'h1234);
    tick();
    tick();
    n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL old_pin_fail: got %b want 1", fail_o); end
    n_cmp++; if (attempts_o !== 2'd2) begin n_bad++; $display("FAIL old_pin_attempts: got %0d want 2", attempts_o); end
    n_cmp++; if (w_o !== 1'b0) begin n_bad++; $display("FAIL old_pin_w: got %b want 0", w_o); end
  endtask

  task automatic test_double_lockout();
    bit tmo;
    logic exp_enr;
`ifdef PIN_VAULT_WIPE_EN
    exp_enr = 1'b0;
`else
    exp_enr = 1'b1;
`endif
    do_reset();
    do_enroll(16'h1234);
    burn_lockout(tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL lockout1_timeout: locked_o still %b want 0", locked_o); end
    n_cmp++; if (enrolled_o !== 1'b1) begin n_bad++; $display("FAIL lockout1_enrolled: got %b want 1", enrolled_o); end
    burn_lockout(tmo);
    n_cmp++; if (tmo) begin n_bad++; $display("FAIL lockout2_timeout: locked_o still %b want 0", locked_o); end
    n_cmp++; if (enrolled_o !== exp_enr) begin n_bad++; $display("FAIL lockout2_enrolled: got %b want %b", enrolled_o, exp_enr); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL lockout2_ready: got %b want 1", ready_o); end
    do_check(16'h1234);
    tick();
    tick();
    n_cmp++; if (w_o !== exp_enr) begin n_bad++; $display("FAIL lockout2_retry_w: got %b want %b", w_o, exp_enr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_enroll(16'h1234);
    for (int i = 0; i < 3; i++) begin
      do_check(16'h1235);
      tick();
      tick();
    end
    tick();
    n_cmp++; if (locked_o !== 1'b1) begin n_bad++; $display("FAIL ar_pre_locked: got %b want 1", locked_o); end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_cmp++; if (locked_o !== 1'b0) begin n_bad++; $display("FAIL ar_locked: got %b want 0", locked_o); end
    n_cmp++; if (enrolled_o !== 1'b0) begin n_bad++; $display("FAIL ar_enrolled: got %b want 0", enrolled_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL ar_ready: got %b want 1", ready_o); end
    n_cmp++; if (attempts_o !== 2'd3) begin n_bad++; $display("FAIL ar_attempts: got %0d want 3", attempts_o); end
    tick();
    rst_n_i = 1'b1;
    do_check(16'h1234);
    n_cmp++; if (fail_o !== 1'b1) begin n_bad++; $display("FAIL ar_pin_lost: fail got %b want 1", fail_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL ar_empty_ready: got %b want 1", ready_o); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_lockout();
    test_bad_bcd();
    test_open_reenroll();
    test_double_lockout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_vault.md
PIN_VAULT -- requirements
Module: pin_vault

Interface
REQ-001 SHALL have parameter MAX_ATTEMPTS, default 3, number of wrong checks allowed before lockout (legal range 1..3).
REQ-002 SHALL have parameter LOCK_CYCLES, default 50000000, lockout duration in clk_i cycles (legal range 1..2^26-1).
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enroll_valid_i  in  1  request to store enroll_pin_i.
REQ-006 SHALL have port enroll_pin_i  in  16  four BCD digits; digit k at [4k+3:4k].
REQ-007 SHALL have port check_valid_i  in  1  request to compare check_pin_i with the stored PIN.
REQ-008 SHALL have port check_pin_i  in  16  candidate PIN, same layout as enroll_pin_i.
REQ-009 SHALL have port relock_i  in  1  close an open vault.
REQ-010 SHALL have port ready_o  out  1  a request is accepted on an edge where ready_o=1 and the request is high.
REQ-011 SHALL have ports enrolled_o, w_o (access granted, level), fail_o (one-cycle pulse), locked_o  out  1 each.
REQ-012 SHALL have port attempts_o  out  2  remaining wrong checks before lockout.

Function
REQ-013 SHALL implement states EMPTY, IDLE, COMPARE, OPEN, LOCKOUT.
REQ-014 EMPTY: ready_o=1; accepted enroll with all digits <=9 stores the PIN, sets enrolled_o=1 and moves to IDLE; invalid BCD or an accepted check pulses fail_o and stays in EMPTY.
REQ-015 IDLE: ready_o=1; an accepted check captures check_pin_i and moves to COMPARE; enroll_valid_i is ignored; if both requests are high, the check wins.
REQ-016 COMPARE lasts exactly one cycle with ready_o=0; w_o rises or fail_o pulses exactly two rising edges after the accepting edge.
REQ-017 Match (all 16 bits equal): move to OPEN, set w_o=1, reload attempts_o to MAX_ATTEMPTS.
REQ-018 Mismatch, or any candidate digit >9: pulse fail_o for one cycle and decrement attempts_o; reaching 0 moves to LOCKOUT, otherwise to IDLE.
REQ-019 OPEN: w_o=1; check_valid_i ignored; a valid-BCD enroll replaces the stored PIN and stays in OPEN; an invalid-BCD enroll pulses fail_o; relock_i moves to IDLE with w_o=0 on the next edge; relock_i has priority over enroll.
REQ-020 LOCKOUT: locked_o=1, ready_o=0; all requests are ignored; a 26-bit timer loaded with LOCK_CYCLES decrements each cycle; at 0, locked_o=0, attempts_o=MAX_ATTEMPTS, and the block moves to IDLE.
REQ-021 The stored PIN SHALL never appear on any output.

Reset
REQ-022 While rst_n_i=0: state EMPTY, stored PIN 0, ready_o=1, enrolled_o=0, w_o=0, fail_o=0, locked_o=0, attempts_o=MAX_ATTEMPTS, timer 0.
REQ-023 Reset asserted in any state, including mid-COMPARE or mid-LOCKOUT, SHALL abort immediately to the REQ-022 values; the stored PIN is lost.

Configuration
REQ-024 Macro PIN_VAULT_WIPE_EN: when defined, a second LOCKOUT entry with no successful match since the previous LOCKOUT SHALL, when the timer expires, clear the stored PIN, set enrolled_o=0 and return to EMPTY instead of IDLE; a successful match clears this history.
REQ-025 Without PIN_VAULT_WIPE_EN, every lockout expiry returns to IDLE and the stored PIN is retained indefinitely.

Verification (bench overrides LOCK_CYCLES=8)
REQ-026 Enroll 16'h1234, then check 16'h1234 -> enrolled_o=1; w_o=1 two edges after acceptance; attempts_o=3.
REQ-027 Enroll 16'h1234, then check 16'h1235 three times -> fail_o pulses three times; attempts_o steps 2,1,0; locked_o=1 for 8 cycles; checks are ignored during lockout; then IDLE with attempts_o=3.
REQ-028 Enroll 16'h12A4 -> fail_o pulse, enrolled_o=0, stays in EMPTY; check in EMPTY -> fail_o pulse.
REQ-029 In OPEN, enroll 16'h9876, assert relock_i, then check 16'h9876 -> w_o falls, then rises again; check 16'h1234 -> fail_o.
REQ-030 With and without PIN_VAULT_WIPE_EN: two consecutive lockouts -> EMPTY/enrolled_o=0 with the macro, IDLE/enrolled_o=1 without it.
REQ-031 Drop rst_n_i for one cycle mid-LOCKOUT -> locked_o=0, enrolled_o=0, ready_o=1 asynchronously.
